midi_uart_rx_fifo: RTL and testbench

MIDI_UART_RX_FIFO -- requirements
Module: midi_uart_rx_fifo

---
 rtl/midi_rx_pkg.sv | 18 +
 rtl/midi_rx_fifo.sv | 70 +++++++
 rtl/midi_uart_rx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_midi_uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_rx_pkg.sv
// midi_rx_pkg
// Shared types and default constants for the MIDI UART receiver slice.
//   rx_state_t        : receiver FSM states
//   OVS_DEFAULT       : oversample ticks per bit
//   DATA_BITS_DEFAULT : data bits per frame
package midi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVS_DEFAULT       = 16;
    localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/midi_rx_fifo.sv
// midi_rx_fifo
// Synchronous first-word-fall-through FIFO holding received bytes.
// Ports:
//   Clk, Rst_n   : clock, asynchronous active-low reset
//   push         : write push_data this cycle (ignored when full unless popping)
//   push_data    : byte to store
//   pop          : consumer takes the head this cycle (ignored when empty)
//   pop_data     : current head, zero when empty
//   valid        : FIFO not empty
//   full         : FIFO holds DEPTH entries
//   count        : occupied entries
module midi_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid    = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && valid;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/midi_uart_rx_fifo.sv
// midi_uart_rx_fifo
// Oversampling UART receiver (8N1-style, configurable data bits) feeding a
// first-word-fall-through receive FIFO.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   RxEn        : receiver enable; low aborts any frame in progress
//   Rx          : asynchronous serial line, idle high
//   out_data    : FIFO head, right-justified, zero-padded
//   out_valid   : FIFO not empty
//   out_ready   : consumer accepts head
//   fifo_count  : occupied FIFO entries
//   frame_err   : one-cycle pulse on a bad stop bit
//   overflow    : sticky, set when a good byte is dropped on a full FIFO
//   ovf_clr     : synchronous clear of overflow
module midi_uart_rx_fifo
    import midi_rx_pkg::*;
#(
    parameter int DIV        = 2,
    parameter int OVS        = OVS_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          RxEn,
    input  logic                          Rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCK_W = $clog2(OVS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TCK_W-1:0] HALF_LAST = TCK_W'(OVS / 2 - 1);
    localparam logic [TCK_W-1:0] FULL_LAST = TCK_W'(OVS - 1);
    localparam logic [3:0]       BITS_LAST = 4'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    rx_state_t            state;
    logic                 armed;
    logic [TCK_W-1:0]     tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 push;
    logic [7:0]           push_data;
    logic                 fifo_full;
    logic                 fifo_pop;

    // Two-flop synchronizer; resets to the idle line level so reset
    // release never looks like a start bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running oversample divider producing a one-cycle tick enable.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // The push is decoded straight from the stop-sample tick so the byte
    // lands in the FIFO on that same edge.
    assign push      = RxEn && tick && (state == STOP) && (tick_cnt == FULL_LAST) && rx_sync;
    assign push_data = 8'(shift_reg);
    assign fifo_pop  = out_valid && out_ready;

    // Receiver FSM. "armed" blocks start detection until the line has been
    // seen high, so a stuck-low line after a framing error or an enable
    // is not mistaken for a new start bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else if (!RxEn) begin
            state     <= IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!armed) begin
                            armed <= rx_sync;
                        end else if (!rx_sync) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_sync ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BITS_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (!rx_sync) begin
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky overflow; a coincident drop wins over a clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    midi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .valid     (out_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_midi_uart_rx_fifo.sv
// tb_midi_uart_rx_fifo
// Directed bench: instance A uses the default 8-bit configuration,
// instance B uses 7 data bits. Bytes are serialised onto Rx at
// DIV*OVS clocks per bit and checked against hand-computed values.
module tb_midi_uart_rx_fifo;

    localparam int BIT_CLKS = 32;

    logic       clk;
    logic       rstN;

    logic       rxEnA, rxA, readyA, ovfClrA;
    logic [7:0] dataA;
    logic       validA, ferrA, ovfA;
    logic [3:0] countA;

    logic       rxEnB, rxB, readyB, ovfClrB;
    logic [7:0] dataB;
    logic       validB, ferrB, ovfB;
    logic [3:0] countB;

    int vecCount  = 0;
    int missCount = 0;
    int acceptA   = 0;
    int ferrCntA  = 0;
    int ferrCntB  = 0;
    int a0, f0;
    logic [7:0] lastA;
    logic       seen;
    logic [7:0] expDrain [8];

    midi_uart_rx_fifo #(.DIV(2), .OVS(16), .DATA_BITS(8), .FIFO_DEPTH(8)) dutA (
        .Clk(clk), .Rst_n(rstN), .RxEn(rxEnA), .Rx(rxA),
        .out_data(dataA), .out_valid(validA), .out_ready(readyA),
        .fifo_count(countA), .frame_err(ferrA), .overflow(ovfA), .ovf_clr(ovfClrA)
    );

    midi_uart_rx_fifo #(.DIV(2), .OVS(16), .DATA_BITS(7), .FIFO_DEPTH(8)) dutB (
        .Clk(clk), .Rst_n(rstN), .RxEn(rxEnB), .Rx(rxB),
        .out_data(dataB), .out_valid(validB), .out_ready(readyB),
        .fifo_count(countB), .frame_err(ferrB), .overflow(ovfB), .ovf_clr(ovfClrB)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observes accepted bytes and frame-error pulses away from the active edge.
    always @(negedge clk) begin
        if (validA && readyA) begin
            acceptA = acceptA + 1;
            lastA   = dataA;
        end
        if (ferrA) ferrCntA = ferrCntA + 1;
        if (ferrB) ferrCntB = ferrCntB + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount = vecCount + 1;
        if (actual !== expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setRx(input bit sel, input logic v);
        if (sel) rxB = v;
        else     rxA = v;
    endtask

    task automatic idleBits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    // Serialises one frame: start, nbits data LSB first, one stop bit.
    // The line is left at the stop level afterwards.
    task automatic applyStimulus(input bit sel, input logic [7:0] data, input int nbits, input logic stopBit);
        @(negedge clk);
        setRx(sel, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            setRx(sel, data[i]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        setRx(sel, stopBit);
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    initial begin
        expDrain = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA5};
        rstN = 1'b0;
        rxEnA = 1'b1; rxA = 1'b1; readyA = 1'b0; ovfClrA = 1'b0;
        rxEnB = 1'b1; rxB = 1'b1; readyB = 1'b0; ovfClrB = 1'b0;
        seen = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_validA", 32'(validA), 32'h0);
        checkOutput("rst_dataA",  32'(dataA),  32'h0);
        checkOutput("rst_countA", 32'(countA), 32'h0);
        checkOutput("rst_ferrA",  32'(ferrA),  32'h0);
        checkOutput("rst_ovfA",   32'(ovfA),   32'h0);
        checkOutput("rst_validB", 32'(validB), 32'h0);
        checkOutput("rst_countB", 32'(countB), 32'h0);
        rstN = 1'b1;
        idleBits(2);

        // Single byte 0x90 with consumer ready
        readyA = 1'b1;
        a0 = acceptA; f0 = ferrCntA;
        applyStimulus(1'b0, 8'h90, 8, 1'b1);
        idleBits(1);
        checkOutput("b90_accepts", 32'(acceptA - a0), 32'd1);
        checkOutput("b90_data",    32'(lastA),        32'h90);
        checkOutput("b90_ferr",    32'(ferrCntA - f0), 32'd0);

        // Short low glitch is rejected, receiver stays usable
        a0 = acceptA;
        @(negedge clk); setRx(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        setRx(1'b0, 1'b1);
        idleBits(2);
        checkOutput("glitch_accepts", 32'(acceptA - a0), 32'd0);
        checkOutput("glitch_count",   32'(countA),       32'd0);
        checkOutput("glitch_ferr",    32'(ferrCntA - f0), 32'd0);
        applyStimulus(1'b0, 8'h3C, 8, 1'b1);
        idleBits(1);
        checkOutput("glitch_next_accepts", 32'(acceptA - a0), 32'd1);
        checkOutput("glitch_next_data",    32'(lastA),        32'h3C);

        // Bad stop bit on 0x45 with the line held low afterwards
        a0 = acceptA; f0 = ferrCntA;
        applyStimulus(1'b0, 8'h45, 8, 1'b0);
        idleBits(12);
        checkOutput("ferr_pulses",  32'(ferrCntA - f0), 32'd1);
        checkOutput("ferr_accepts", 32'(acceptA - a0),  32'd0);
        setRx(1'b0, 1'b1);
        idleBits(2);
        applyStimulus(1'b0, 8'h5A, 8, 1'b1);
        idleBits(1);
        checkOutput("ferr_next_accepts", 32'(acceptA - a0),  32'd1);
        checkOutput("ferr_next_data",    32'(lastA),         32'h5A);
        checkOutput("ferr_next_pulses",  32'(ferrCntA - f0), 32'd1);

        // Nine bytes into an eight-entry FIFO with no consumer
        readyA = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 8'(i * 8'h11), 8, 1'b1);
        end
        idleBits(1);
        checkOutput("full_count", 32'(countA), 32'd8);
        checkOutput("full_ovf",   32'(ovfA),   32'd1);
        checkOutput("full_head",  32'(dataA),  32'h11);
        checkOutput("full_valid", 32'(validA), 32'd1);
        ovfClrA = 1'b1;
        @(negedge clk);
        ovfClrA = 1'b0;
        checkOutput("ovf_clr", 32'(ovfA), 32'd0);

        // Push into a full FIFO while the head is popped in the same cycle
        fork
            applyStimulus(1'b0, 8'hA5, 8, 1'b1);
            begin
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge clk);
                    if (dutA.push) seen = 1'b1;
                end
                if (seen) begin
                    readyA = 1'b1;
                    @(negedge clk);
                    readyA = 1'b0;
                end
            end
        join
        checkOutput("simul_push_seen", 32'(seen), 32'd1);
        idleBits(1);
        checkOutput("simul_count", 32'(countA), 32'd8);
        checkOutput("simul_ovf",   32'(ovfA),   32'd0);
        checkOutput("simul_head",  32'(dataA),  32'h22);
        readyA = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_data", 32'(dataA), 32'(expDrain[i]));
            @(negedge clk);
        end
        readyA = 1'b0;
        checkOutput("drain_count", 32'(countA), 32'd0);
        checkOutput("drain_valid", 32'(validA), 32'd0);

        // Seven data bits on instance B
        applyStimulus(1'b1, 8'h7F, 7, 1'b1);
        idleBits(1);
        checkOutput("b7_valid", 32'(validB), 32'd1);
        checkOutput("b7_data",  32'(dataB),  32'h7F);
        checkOutput("b7_count", 32'(countB), 32'd1);
        readyB = 1'b1;
        @(negedge clk);
        readyB = 1'b0;
        checkOutput("b7_pop_count", 32'(countB), 32'd0);

        // Enable dropped mid-frame: neither a push nor a frame error
        f0 = ferrCntB;
        fork
            applyStimulus(1'b1, 8'h12, 7, 1'b0);
            begin
                repeat (4 * BIT_CLKS) @(negedge clk);
                rxEnB = 1'b0;
            end
        join
        idleBits(1);
        setRx(1'b1, 1'b1);
        idleBits(1);
        rxEnB = 1'b1;
        idleBits(2);
        checkOutput("abort_count", 32'(countB),        32'd0);
        checkOutput("abort_valid", 32'(validB),        32'd0);
        checkOutput("abort_ferr",  32'(ferrCntB - f0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
